// File: rtl/wrr_packet_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared types and helpers for the packet arbiters in the tree.
// Revision: 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int c_default_timeout = 255;

    // Index width for n requesters; a 1-bit index is the floor.
    function automatic int calc_iw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrr_packet_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : wrr_packet_arbiter_if
// Brief   : Requester-side and downstream valid/ready/data/last bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface wrr_packet_arbiter_if #(
    parameter int bus_num = 8,
    parameter int DW      = 8
);
    logic [bus_num-1:0]    valid_in;
    logic [bus_num*DW-1:0] data_in;
    logic [bus_num-1:0]    last_in;
    logic [bus_num-1:0]    ready_out;
    logic                  valid_out;
    logic [DW-1:0]         data_out;
    logic                  last_out;
    logic                  ready_in;

    // slave: the arbiter itself; master: the surrounding requesters and sink
    modport slave (
        input  valid_in, data_in, last_in, ready_in,
        output ready_out, valid_out, data_out, last_out
    );

    modport master (
        output valid_in, data_in, last_in, ready_in,
        input  ready_out, valid_out, data_out, last_out
    );
endinterface
`default_nettype wire

// File: rtl/wrr_packet_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Brief   : Combinational circular first-one finder starting at ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int bus_num = 8,
    parameter int IW      = calc_iw(bus_num)
) (
    input  wire [bus_num-1:0] req,
    input  wire [IW-1:0]      ptr,
    output logic [IW-1:0]     idx,
    output logic              found
);

    always_comb begin
        int w_pos;
        idx   = '0;
        found = 1'b0;
        w_pos = 0;
        for (int k = 0; k < bus_num; k++) begin
            w_pos = (int'(ptr) + k) % bus_num;
            if (!found && req[w_pos]) begin
                found = 1'b1;
                idx   = IW'(w_pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wrr_packet_arbiter
// Brief   : Packet-atomic weighted round-robin arbiter, registered output.
//           Optional stall timeout with forced release: ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module wrr_packet_arbiter
    import arb_pkg::*;
#(
    parameter int bus_num = 8,
    parameter int DW      = 8,
    parameter int WW      = 4,
    parameter int IW      = calc_iw(bus_num),
    parameter int TIMEOUT = c_default_timeout
) (
    input  wire                    clk,
    input  wire                    rst,
    wrr_packet_arbiter_if.slave    bus,
    input  wire [bus_num*WW-1:0]   weight_cfg,
    output logic [IW-1:0]          grant_idx,
    output logic                   timeout_err
);

    if (TIMEOUT < 1 || IW != calc_iw(bus_num)) begin : g_param_check
        $error("wrr_packet_arbiter: IW must equal clog2(bus_num) and TIMEOUT must be >= 1");
    end

    arb_state_e     r_state, w_state_next;
    logic [IW-1:0]  r_ptr, w_ptr_next;
    logic [IW-1:0]  r_grant, w_grant_next, w_grant_succ;
    logic [WW-1:0]  r_credit, w_credit_next, w_pick_weight;
    logic           r_at_boundary, w_at_boundary_next;
    logic           r_valid, r_last, r_timeout_err;
    logic [DW-1:0]  r_data;
    logic [IW-1:0]  w_pick_idx;
    logic           w_pick_found, w_load_en, w_accept, w_timeout, w_release;
    logic           w_grant_valid, w_grant_last;
    logic [DW-1:0]  w_grant_data;

    rr_pick #(.bus_num(bus_num), .IW(IW)) u_pick (
        .req   (bus.valid_in),
        .ptr   (r_ptr),
        .idx   (w_pick_idx),
        .found (w_pick_found)
    );

    assign w_load_en     = ~r_valid | bus.ready_in;
    assign w_grant_valid = bus.valid_in[r_grant];
    assign w_grant_last  = bus.last_in[r_grant];
    assign w_grant_data  = bus.data_in[DW*int'(r_grant) +: DW];
    assign w_accept      = (r_state == BUSY) & w_grant_valid & w_load_en;
    assign w_pick_weight = weight_cfg[WW*int'(w_pick_idx) +: WW];
    assign w_grant_succ  = (r_grant == IW'(bus_num - 1)) ? '0 : r_grant + 1'b1;

    for (genvar i = 0; i < bus_num; i++) begin : g_ready
        assign bus.ready_out[i] = (r_state == BUSY) & (r_grant == IW'(i)) & w_load_en;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int c_cw = $clog2(TIMEOUT + 1);
    logic [c_cw-1:0] r_stall;
    logic            w_stalling;

    assign w_stalling = (r_state == BUSY) & ~r_at_boundary & ~w_grant_valid;
    assign w_timeout  = w_stalling & (r_stall == c_cw'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
        end else if (w_timeout || r_state == IDLE || w_accept) begin
            r_stall <= '0;
        end else if (w_stalling) begin
            r_stall <= r_stall + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // r_at_boundary: a packet ended and the grantee has credit left, so an
    // absent valid means it has nothing more to send this turn.
    always_comb begin
        w_state_next       = r_state;
        w_ptr_next         = r_ptr;
        w_grant_next       = r_grant;
        w_credit_next      = r_credit;
        w_at_boundary_next = r_at_boundary;
        w_release          = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_next       = BUSY;
                    w_grant_next       = w_pick_idx;
                    w_credit_next      = (w_pick_weight == '0) ? WW'(1) : w_pick_weight;
                    w_at_boundary_next = 1'b0;
                end
            end
            BUSY: begin
                if (w_accept) begin
                    w_at_boundary_next = w_grant_last;
                    if (w_grant_last) begin
                        w_credit_next = r_credit - 1'b1;
                        w_release     = (r_credit == WW'(1));
                    end
                end else if (r_at_boundary && !w_grant_valid) begin
                    w_release = 1'b1;
                end else if (w_timeout) begin
                    w_release = 1'b1;
                end
                if (w_release) begin
                    w_state_next = IDLE;
                    w_ptr_next   = w_grant_succ;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_grant       <= '0;
            r_credit      <= '0;
            r_at_boundary <= 1'b0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
            r_data        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ptr         <= w_ptr_next;
            r_grant       <= w_grant_next;
            r_credit      <= w_credit_next;
            r_at_boundary <= w_at_boundary_next;
            r_timeout_err <= w_timeout;
            if (w_load_en) begin
                r_valid <= w_accept;
                r_last  <= w_accept & w_grant_last;
                if (w_accept) begin
                    r_data <= w_grant_data;
                end
            end
        end
    end

    assign bus.valid_out = r_valid;
    assign bus.data_out  = r_data;
    assign bus.last_out  = r_last;
    assign grant_idx     = r_grant;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_wrr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wrr_packet_arbiter
// Brief   : Table-driven and scoreboard bench for wrr_packet_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_wrr_packet_arbiter;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic [2:0] src;
        logic       last;
        logic [7:0] data;
        logic [3:0] gap;     // idle output cycles before this beat; 4'hF = don't care
    } exp_t;

    typedef struct packed {
        logic [31:0]       w;
        int                nbeat;
        int                nexp;
        logic [0:7][3:0]   order;
        logic [0:7][3:0]   gap;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] weight_cfg;
    logic [2:0]  grant_idx;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int idle_run = 0;
    int tmo_cnt  = 0;

    beat_t src_q [8][$];
    exp_t  exp_q [$];
    vec_t  tbl [6];

    wrr_packet_arbiter_if #(.bus_num(8), .DW(8)) bus ();

    wrr_packet_arbiter #(
        .bus_num(8), .DW(8), .WW(4), .IW(3), .TIMEOUT(10)
    ) dut (
        .clk         (clk),
        .rst         (rst_n),
        .bus         (bus),
        .weight_cfg  (weight_cfg),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_src(input int i, input logic v, input logic [7:0] d, input logic l);
        src_q[i].push_back('{v: v, d: d, l: l});
    endfunction

    function automatic void push_exp(input int s, input logic [7:0] d, input logic l, input logic [3:0] g);
        exp_q.push_back('{src: 3'(s), last: l, data: d, gap: g});
    endfunction

    // Requester models: each queue front is driven; a beat leaves on transfer,
    // a bubble (v=0) leaves after one cycle.
    initial begin
        logic [7:0] drove_bub;
        bus.valid_in = '0;
        bus.data_in  = '0;
        bus.last_in  = '0;
        drove_bub    = '0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 8; i++) begin
                if (src_q[i].size() > 0) begin
                    if (drove_bub[i] || (bus.valid_in[i] && bus.ready_out[i]))
                        void'(src_q[i].pop_front());
                end
            end
            #1;
            for (int i = 0; i < 8; i++) begin
                if (src_q[i].size() > 0) begin
                    bus.valid_in[i]       = src_q[i][0].v;
                    bus.data_in[i*8 +: 8] = src_q[i][0].d;
                    bus.last_in[i]        = src_q[i][0].l;
                    drove_bub[i]          = ~src_q[i][0].v;
                end else begin
                    bus.valid_in[i] = 1'b0;
                    bus.last_in[i]  = 1'b0;
                    drove_bub[i]    = 1'b0;
                end
            end
        end
    end

    // Output monitor: compares each downstream transfer with the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (timeout_err) tmo_cnt++;
        if (!rst_n) begin
            idle_run = 0;
        end else if (bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got src=%0d data=%0h last=%0b expected no beat",
                         grant_idx, bus.data_out, bus.last_out);
            end else begin
                e = exp_q.pop_front();
                check("beat{src,last,data}", {grant_idx, bus.last_out, bus.data_out},
                      {e.src, e.last, e.data});
                if (e.gap != 4'hF) check("idle_gap", 64'(idle_run), 64'(e.gap));
            end
            idle_run = 0;
        end else if (!bus.valid_out) begin
            idle_run++;
        end
    end

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic sync_on(input string name, input logic [7:0] d, input int max_cyc);
        logic found;
        found = 1'b0;
        for (int n = 0; n < max_cyc && !found; n++) begin
            @(negedge clk);
            found = bus.valid_out && (bus.data_out == d);
        end
        check(name, 64'(found), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        rst_n         = 1'b0;
        bus.ready_in  = 1'b1;
        weight_cfg    = '0;

        tbl[0] = '{w: 32'h11111111, nbeat: 2, nexp: 6, order: 32'h02502500, gap: 32'hF1111100};
        tbl[1] = '{w: 32'h11111111, nbeat: 1, nexp: 2, order: 32'h70000000, gap: 32'hF1000000};
        tbl[2] = '{w: 32'h11111111, nbeat: 1, nexp: 3, order: 32'h00000000, gap: 32'hF1100000};
        tbl[3] = '{w: 32'h11111111, nbeat: 3, nexp: 2, order: 32'h12000000, gap: 32'hF1000000};
        tbl[4] = '{w: 32'h00000013, nbeat: 1, nexp: 8, order: 32'h00010001, gap: 32'hF0011001};
        tbl[5] = '{w: 32'h00000000, nbeat: 1, nexp: 8, order: 32'h23012301, gap: 32'hF1111111};

        repeat (3) @(negedge clk);
        check("reset_state", {bus.valid_out, bus.last_out, bus.data_out, grant_idx,
                              timeout_err, bus.ready_out}, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 6; r++) begin
            int pkt_cnt [8];
            weight_cfg = tbl[r].w;
            for (int i = 0; i < 8; i++) pkt_cnt[i] = 0;
            for (int k = 0; k < tbl[r].nexp; k++) begin
                int s;
                s = int'(tbl[r].order[k]);
                for (int b = 0; b < tbl[r].nbeat; b++) begin
                    logic [7:0] d;
                    logic       l;
                    d = 8'(s*32 + pkt_cnt[s]*4 + b);
                    l = (b == tbl[r].nbeat - 1);
                    push_src(s, 1'b1, d, l);
                    push_exp(s, d, l, (b == 0) ? tbl[r].gap[k] : 4'd0);
                end
                pkt_cnt[s]++;
            end
            wait_drain("table_drain", 400);
        end

        // Mid-packet valid drop holds the grant; requester 4 must wait.
        weight_cfg = 32'h11111111;
        push_src(3, 1'b1, 8'hA0, 1'b0);
        push_src(3, 1'b1, 8'hA1, 1'b0);
        for (int i = 0; i < 5; i++) push_src(3, 1'b0, 8'h00, 1'b0);
        push_src(3, 1'b1, 8'hA2, 1'b0);
        push_src(3, 1'b1, 8'hA3, 1'b1);
        push_src(4, 1'b1, 8'hB0, 1'b1);
        push_exp(3, 8'hA0, 1'b0, 4'hF);
        push_exp(3, 8'hA1, 1'b0, 4'd0);
        push_exp(3, 8'hA2, 1'b0, 4'd5);
        push_exp(3, 8'hA3, 1'b1, 4'd0);
        push_exp(4, 8'hB0, 1'b1, 4'd1);
        sync_on("sync_A1", 8'hA1, 50);
        check("hold_ready_out", 64'(bus.ready_out), 64'h08);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check("hold_ready_out", 64'(bus.ready_out), 64'h08);
        end
        wait_drain("drop_drain", 100);

        // Downstream stall mid-packet.
        for (int b = 0; b < 4; b++) push_src(1, 1'b1, 8'(8'hC0 + b), b == 3);
        push_exp(1, 8'hC0, 1'b0, 4'hF);
        push_exp(1, 8'hC1, 1'b0, 4'd0);
        push_exp(1, 8'hC2, 1'b0, 4'd0);
        push_exp(1, 8'hC3, 1'b1, 4'd0);
        sync_on("sync_C1", 8'hC1, 50);
        @(posedge clk);
        #1 bus.ready_in = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("stall_hold{valid,data,ready}", {bus.valid_out, bus.data_out, bus.ready_out},
                  {1'b1, 8'hC2, 8'h00});
        end
        @(posedge clk);
        #1 bus.ready_in = 1'b1;
        wait_drain("stall_drain", 100);

        // Asynchronous reset mid-packet, then requester 0 wins first.
        for (int b = 0; b < 4; b++) push_src(2, 1'b1, 8'(8'hD0 + b), b == 3);
        push_src(0, 1'b1, 8'h11, 1'b1);
        push_exp(2, 8'hD0, 1'b0, 4'hF);
        push_exp(2, 8'hD1, 1'b0, 4'd0);
        sync_on("sync_D1", 8'hD1, 50);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {bus.valid_out, bus.last_out, bus.data_out, grant_idx, timeout_err},
              64'd0);
        for (int i = 0; i < 8; i++) src_q[i].delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_src(0, 1'b1, 8'hE0, 1'b1);
        push_src(2, 1'b1, 8'hF0, 1'b1);
        push_exp(0, 8'hE0, 1'b1, 4'hF);
        push_exp(2, 8'hF0, 1'b1, 4'd1);
        wait_drain("post_reset_drain", 100);

`ifdef ARB_TIMEOUT_EN
        // Grantee abandons its packet; forced release after 10 stall cycles.
        push_src(6, 1'b1, 8'h60, 1'b0);
        push_src(7, 1'b1, 8'h70, 1'b1);
        push_exp(6, 8'h60, 1'b0, 4'hF);
        push_exp(7, 8'h70, 1'b1, 4'd11);
        begin
            logic seen;
            seen = 1'b0;
            for (int n = 0; n < 60 && !seen; n++) begin
                @(negedge clk);
                seen = timeout_err;
            end
            check("timeout_seen", 64'(seen), 64'd1);
            @(negedge clk);
            check("after_timeout{err,grant}", {timeout_err, grant_idx}, {1'b0, 3'd7});
        end
        wait_drain("timeout_drain", 100);
        check("timeout_pulses", 64'(tmo_cnt), 64'd1);
`else
        check("timeout_pulses", 64'(tmo_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
